// File: rtl/output_drain.sv
// output_drain: streams words out of the output SRAM over a valid/ready
// handshake. The block issues read addresses, absorbs the SRAM's one-cycle
// read latency, and buffers results in a 2-entry {data, last} FIFO. Issue is
// throttled so that words already in flight always have a free slot, which
// lets arbitrary consumer backpressure be tolerated.
module output_drain #(
    parameter int DWIDTH  = 16,
    parameter int OUTSIZE = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [OUTSIZE:0]         count,
    output logic                     busy,
    output logic                     done,
    output logic [OUTSIZE-1:0]       mem_addr,
    input  logic signed [DWIDTH-1:0] read_data,
    output logic                     m_valid,
    output logic signed [DWIDTH-1:0] m_data,
    output logic                     m_last,
    input  logic                     m_ready
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    localparam logic [OUTSIZE:0] ONE = {{OUTSIZE{1'b0}}, 1'b1};

    state_t                     state_q;
    logic [OUTSIZE:0]           count_q;
    logic [OUTSIZE:0]           addr_q;
    logic [OUTSIZE:0]           cap_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       inflight_q;

    // FIFO: head entry drives the output port directly, tail is the spare slot
    logic                       hv_q;
    logic                       hl_q;
    logic signed [DWIDTH-1:0]   hd_q;
    logic                       tv_q;
    logic                       tl_q;
    logic signed [DWIDTH-1:0]   td_q;

    logic [1:0]                 occ;
    logic [2:0]                 pending;
    logic                       pop;
    logic                       push;
    logic                       issue;
    logic                       last_in;
    logic                       empty_next;

    // Issue throttling, capture tagging and next-cycle FIFO emptiness
    always_comb begin
        occ        = {1'b0, hv_q} + {1'b0, tv_q};
        pop        = hv_q & m_ready;
        push       = inflight_q;
        pending    = {1'b0, occ} + {2'b0, inflight_q};
        issue      = (state_q == READ) && (pending < (3'd2 + {2'b0, pop}));
        last_in    = (cap_q == (count_q - ONE));
        empty_next = ((pending - {2'b0, pop}) == 3'd0);
    end

    // Control FSM with address and capture counters; outputs are registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            addr_q  <= '0;
            cap_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (push) begin
                cap_q <= cap_q + ONE;
            end
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        count_q <= count;
                        addr_q  <= '0;
                        cap_q   <= '0;
                        if (count != '0) begin
                            state_q <= READ;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        addr_q <= addr_q + ONE;
                        if (addr_q == (count_q - ONE)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Finish on the edge that empties the pipeline so done
                    // follows the final handshake by exactly one cycle.
                    if (empty_next) begin
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                FIN: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Two-entry output FIFO plus the in-flight read marker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
            hv_q       <= 1'b0;
            hl_q       <= 1'b0;
            hd_q       <= '0;
            tv_q       <= 1'b0;
            tl_q       <= 1'b0;
            td_q       <= '0;
        end else begin
            inflight_q <= issue;
            if (!hv_q || pop) begin
                if (tv_q) begin
                    hv_q <= 1'b1;
                    hd_q <= td_q;
                    hl_q <= tl_q;
                end else if (push) begin
                    hv_q <= 1'b1;
                    hd_q <= read_data;
                    hl_q <= last_in;
                end else begin
                    hv_q <= 1'b0;
                    hl_q <= 1'b0;
                end
            end
            if (tv_q) begin
                if (pop) begin
                    tv_q <= push;
                    if (push) begin
                        td_q <= read_data;
                        tl_q <= last_in;
                    end
                end
            end else if (push && hv_q && !pop) begin
                tv_q <= 1'b1;
                td_q <= read_data;
                tl_q <= last_in;
            end
        end
    end

    // A push into a full FIFO with no pop would drop a word
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (occ == 2'd2)));

    assign busy     = busy_q;
    assign done     = done_q;
    assign mem_addr = addr_q[OUTSIZE-1:0];
    assign m_valid  = hv_q;
    assign m_data   = hd_q;
    assign m_last   = hl_q;

endmodule

// File: tb/tb_output_drain.sv
// Bench for output_drain: an SRAM model with one-cycle registered-address
// reads, randomized consumer backpressure, and a reference that expects
// words mem[0..count-1] in order with last on the final one.
module tb_output_drain;

    localparam int DW = 16;
    localparam int AW = 10;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [AW:0]          count = '0;
    logic                 busy;
    logic                 done;
    logic [AW-1:0]        mem_addr;
    logic signed [DW-1:0] read_data;
    logic                 m_valid;
    logic signed [DW-1:0] m_data;
    logic                 m_last;
    logic                 m_ready = 1'b0;

    logic signed [DW-1:0] mem [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;

    output_drain #(.DWIDTH(DW), .OUTSIZE(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .read_data (read_data),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready)
    );

    always #5 clk = ~clk;

    // SRAM: data appears one cycle after the address is presented
    always @(posedge clk) read_data <= mem[mem_addr];

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, want);
        end
    endtask

    // One drain of n words with m_ready high pct% of cycles; if poke_at >= 0,
    // a start with count=2 is raised at that cycle of the drain.
    task automatic run(input int n, input int pct, input int poke_at);
        int got;
        int cyc;
        bit stalled;
        bit seen_done;
        bit rdy;
        logic signed [DW-1:0] pd;
        logic pl;
        got = 0; cyc = 0; stalled = 0; seen_done = 0; pd = '0; pl = 1'b0;
        @(negedge clk);
        start = 1'b1; count = n[AW:0]; m_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, (n != 0));
        if (n != 0) check("addr_first", mem_addr, 0);
        while (!seen_done && cyc < 4*n + 50) begin
            if (done) begin
                seen_done = 1;
                check("beats_at_done", got, n);
                check("busy_at_done", busy, 0);
                check("valid_at_done", m_valid, 0);
            end else begin
                if (stalled) begin
                    check("hold_valid", m_valid, 1);
                    check("hold_data", m_data, pd);
                    check("hold_last", m_last, pl);
                end
                if (pct == 100 && got > 0 && got < n) check("no_gap", m_valid, 1);
                rdy = ($urandom_range(99, 0) < pct);
                m_ready = rdy;
                if (m_valid && rdy) begin
                    if (got < n) begin
                        check("data", m_data, mem[got]);
                        check("last", m_last, (got == n - 1));
                    end else begin
                        check("extra_beat", got, n);
                    end
                    got++;
                end
                stalled = m_valid && !rdy;
                pd = m_data;
                pl = m_last;
                if (cyc == poke_at) begin
                    start = 1'b1;
                    count = 2;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        check("done_seen", seen_done, 1);
        start = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        check("done_single", done, 0);
        check("idle_valid", m_valid, 0);
    endtask

    initial begin
        int beats;
        int cyc;
        bit dseen;
        for (int i = 0; i < (1<<AW); i++) mem[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", m_valid, 0);
        check("rst_last", m_last, 0);
        check("rst_data", m_data, 0);
        check("rst_addr", mem_addr, 0);
        rst = 1'b0;

        mem[0] = 16'sd5; mem[1] = -16'sd7; mem[2] = 16'sd100; mem[3] = 16'sd32767;
        run(4, 100, -1);

        for (int i = 0; i < 64; i++) mem[i] = 16'(i);
        run(64, 50, -1);

        run(0, 100, -1);
        mem[0] = -16'sd1234;
        run(1, 100, -1);
        run(1, 30, -1);

        for (int i = 0; i < (1<<AW); i++) mem[i] = 16'(i) ^ 16'h5A5A;
        run(1024, 100, -1);

        for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
        run(8, 100, 3);
        run(8, 50, 2);

        for (int i = 0; i < 16; i++) mem[i] = 16'(100 + i);
        @(negedge clk);
        start = 1'b1; count = 16; m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        beats = 0; cyc = 0; dseen = 0;
        while (beats < 3 && cyc < 40) begin
            if (m_valid) beats++;
            if (done) dseen = 1;
            @(negedge clk);
            cyc++;
        end
        check("beats_before_rst", beats, 3);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_last", m_last, 0);
        check("mid_rst_data", m_data, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("no_done_mid", dseen, 0);
        @(negedge clk);
        check("rst_held_done", done, 0);
        rst = 1'b0;
        m_ready = 1'b0;
        run(2, 100, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/output_drain.md
# output_drain

Streams the contents of the output SRAM (`sram_output`) to a downstream consumer over a valid/ready handshake once a layer has finished writing results. It sits directly downstream of `sram_output`, drives its read address, absorbs the SRAM's one-cycle registered-address read latency, and tolerates arbitrary consumer backpressure without losing or duplicating words. Write access to the SRAM (`mem_we`, `write_data`) is not driven here. An external mux gives the SRAM address to this block while `busy` is high.

## Interface
- `DWIDTH`, 16: data word width. Must match `sram_output`.
- `OUTSIZE`, 10: SRAM address width. Depth is 2^OUTSIZE words.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: begin a drain. Sampled only in IDLE.
- `count`  in  OUTSIZE+1: number of words to stream, 0..2^OUTSIZE. Latched on an accepted `start`.
- `busy`  out  1: high from the cycle after an accepted `start` until `done`.
- `done`  out  1: one-cycle pulse when the drain completes.
- `mem_addr`  out  OUTSIZE: read address to `sram_output`.
- `read_data`  in  DWIDTH signed: SRAM data for the address presented in the previous cycle.
- `m_valid`  out  1: output beat valid.
- `m_data`  out  DWIDTH signed: output beat data, driven from a register.
- `m_last`  out  1: marks the final beat. Qualified by `m_valid`.
- `m_ready`  in  1: consumer accepts the beat when `m_valid & m_ready`.

## Operation
- **States**
  - IDLE: default state.
  - READ: issuing addresses.
  - DRAIN: all addresses issued, waiting for the buffer to empty.
  - FIN: one cycle. Asserts `done`, then returns to IDLE.
- **Transitions**
  - IDLE → READ on `start` with `count != 0`. Load address counter = 0 and remaining = `count`.
  - IDLE → FIN on `start` with `count == 0`. No beats are produced.
  - READ → DRAIN on the cycle the last address (`count-1`) is issued.
  - DRAIN → FIN when the buffer is empty, no read is in flight, and the last beat has been handshaken.
  - `start` outside IDLE is ignored. The latched `count` is not changed.
- **Buffer:** 2-entry FIFO of {data, last}. `m_valid`/`m_data`/`m_last` reflect the head entry.
- **Issue rule:** issue = (state == READ) & (occ + inflight − pop < 2).
  - occ: FIFO occupancy.
  - inflight: registered copy of last cycle's issue.
  - pop: `m_valid & m_ready`.
- **On issue:** the address counter increments. `mem_addr` always shows the counter value.
- **When not issuing:** the SRAM re-reads `mem_addr`. Because `inflight` = 0, that data is discarded.
- **Capture:** when `inflight` = 1, push `read_data` with last = (captured word index == `count-1`).
  - Push and pop in the same cycle are allowed.
  - The FIFO never overflows; overflow is an assertion failure.
- **Counter width:** the address counter is OUTSIZE+1 bits. `mem_addr` is its low OUTSIZE bits, so `count` = 2^OUTSIZE drains addresses 0..2^OUTSIZE−1 without early wrap.
- **Throughput:** 1 word/cycle under continuous `m_ready`.

## Timing
- **Reset values:** state IDLE; `busy` = 0, `done` = 0, `m_valid` = 0, `m_last` = 0, `m_data` = 0, `mem_addr` = 0; FIFO empty, `inflight` = 0.
- **Reset mid-drain:** `rst` clears everything immediately, asynchronously. Partial output is abandoned, and there is no `done` pulse.
- **Start and first beat:** `start` is sampled at edge E0. In cycle E0+1, `busy` = 1 and `mem_addr` = 0. Word 0 is pushed at E0+2. `m_valid` is first high in cycle E0+2→E0+3, giving a first-beat latency of 2 edges after E0.
- **Completion:** final handshake at edge Ef. `done` = 1 and `busy` = 0 in the cycle after Ef. State is IDLE one cycle later, and `start` is accepted then.
- **Zero count:** `count` = 0 gives `done` one cycle after the accepted `start`. `m_valid` is never asserted.
- **Output stability:** while `m_valid & !m_ready`, `m_data` and `m_last` hold stable.

## Test plan
- **Continuous drain:** preload mem[0..3] = 5, −7, 100, 32767; `count` = 4, `m_ready` = 1. Expect 4 consecutive beats 5, −7, 100, 32767, with `m_last` only on the 4th, then a single `done`.
- **Random backpressure:** `count` = 64, mem[i] = i, `m_ready` random at 50%. Expect beats 0..63 in order, no gaps or duplicates, data stable while stalled, FIFO never overflows.
- **Boundary counts:**
  - `count` = 0: `done` one cycle after `start`, zero beats.
  - `count` = 1: a single beat with `m_last` = 1.
  - `count` = 1024 (full depth): addresses 0..1023 each read once, `m_last` on address 1023.
- **Start while busy:** assert `start` with `count` = 2 during a `count` = 8 drain. Exactly 8 beats, one `done`.
- **Reset mid-op:** assert `rst` after 3 beats of a 16-word drain. All outputs go to reset values immediately, with no `done`. A new `count` = 2 drain then returns mem[0], mem[1].
